mac_operand_sequencer: RTL and testbench

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

---
 rtl/mac_operand_sequencer_pkg.sv | 23 ++
 rtl/mac_operand_sequencer_op_fifo.sv | 69 ++++++
 rtl/mac_operand_sequencer.sv | 133 +++++++++++++
 tb/tb_mac_operand_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_operand_sequencer_pkg.sv
// Shared definitions for the MAC operand sequencer.
//   seq_state_t    : sequencer FSM states (IDLE, PRESENT, HOLD)
//   DEFAULT_DEPTH  : default operand FIFO depth
//   DEFAULT_DW     : default operand width
//   DEFAULT_ENTRY_W: entry width {a, b, clr} for the default operand width
//   entry_width()  : entry width for any operand width (2*dw+1)
package mac_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } seq_state_t;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_DW      = 8;
  localparam int DEFAULT_ENTRY_W = 2 * DEFAULT_DW + 1;

  function automatic int entry_width(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/mac_operand_sequencer_op_fifo.sv
// Synchronous operand FIFO with a registered occupancy count.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push      : write wdata this edge (ignored when full)
//   pop       : drop the head entry this edge (ignored when empty)
//   wdata     : entry to write
//   rdata     : current head entry (valid when empty is low)
//   level     : registered number of stored entries, 0..DEPTH
//   full      : level == DEPTH
//   empty     : level == 0
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// MAC operand sequencer: queues {a, b, clr} entries from a host and presents
// them one at a time to a MAC change-detect interface, holding each entry for
// at least max(hold_cycles, 1) cycles.
// Handshake: an entry is accepted on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the registered FIFO level
// (a same-cycle pop does not raise it), and in_valid may not depend on in_ready.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : host entry handshake
//   in_a, in_b, in_clr: offered entry
//   hold_cycles       : hold time per entry, sampled when an entry is presented
//   data_a, data_b    : registered operands to the MAC
//   clear_mult        : registered clear level to the MAC
//   op_strobe         : pulse in the first cycle of each presented entry
//   dup_pair          : pulse with op_strobe when the entry repeats the previous one
//   busy              : presenting/holding an entry or entries queued
//   fifo_level        : registered FIFO occupancy
module mac_operand_sequencer
  import mac_operand_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = DEFAULT_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_a,
  input  logic [DW-1:0]          in_b,
  input  logic                   in_clr,
  input  logic [3:0]             hold_cycles,
  output logic [DW-1:0]          data_a,
  output logic [DW-1:0]          data_b,
  output logic                   clear_mult,
  output logic                   op_strobe,
  output logic                   dup_pair,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int EW = entry_width(DW);

  seq_state_t    state;
  seq_state_t    state_next;
  logic [3:0]    hold_cnt;
  logic [3:0]    hold_cnt_next;
  logic          load;
  logic          push;
  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  op_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (load),
    .wdata ({in_a, in_b, in_clr}),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // hold_cnt holds the number of cycles still to run after the current one,
  // so an entry occupies PRESENT plus hold_cnt HOLD cycles in total.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    load          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      ST_PRESENT, ST_HOLD: begin
        if (hold_cnt != 4'd0) begin
          state_next    = ST_HOLD;
          hold_cnt_next = hold_cnt - 4'd1;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (load) begin
      state_next    = ST_PRESENT;
      // A hold of 0 behaves like 1: no extra cycles after PRESENT.
      hold_cnt_next = (hold_cycles == 4'd0) ? 4'd0 : hold_cycles - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Outputs only move on a presentation edge; reset value 0 matches the
  // MAC change detector's own reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a     <= '0;
      data_b     <= '0;
      clear_mult <= 1'b0;
      op_strobe  <= 1'b0;
      dup_pair   <= 1'b0;
    end else begin
      op_strobe <= load;
      dup_pair  <= load && (head == {data_a, data_b, clear_mult});
      if (load) begin
        {data_a, data_b, clear_mult} <= head;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int EW    = 2 * DW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_clr;
  logic [3:0]    hold_cycles;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          clear_mult;
  logic          op_strobe;
  logic          dup_pair;
  logic          busy;
  logic [2:0]    fifo_level;

  mac_operand_sequencer #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_clr      (in_clr),
    .hold_cycles (hold_cycles),
    .data_a      (data_a),
    .data_b      (data_b),
    .clear_mult  (clear_mult),
    .op_strobe   (op_strobe),
    .dup_pair    (dup_pair),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued entries, the entry on the outputs, and the
  // earliest edge at which the next entry may be presented.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur;
  longint        cyc;
  longint        next_free;
  logic          exp_strobe;
  logic          exp_dup;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("op_strobe",  32'(op_strobe),  32'(exp_strobe));
    chk("dup_pair",   32'(dup_pair),   32'(exp_dup));
    chk("data_a",     32'(data_a),     32'(cur[EW-1 -: DW]));
    chk("data_b",     32'(data_b),     32'(cur[DW:1]));
    chk("clear_mult", 32'(clear_mult), 32'(cur[0]));
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("in_ready",   32'(in_ready),   32'(exp_q.size() != DEPTH));
    chk("busy",       32'(busy),       32'((exp_q.size() > 0) || (cyc < next_free)));
  endtask

  // One clock: apply the model's rules for this edge, then check at negedge.
  task automatic tick();
    bit            push_now;
    logic [EW-1:0] pe;
    logic [EW-1:0] e;
    int            h;
    push_now = in_valid && (exp_q.size() != DEPTH);
    pe       = {in_a, in_b, in_clr};
    h        = (hold_cycles == 4'd0) ? 1 : int'(hold_cycles);
    @(posedge clk);
    cyc++;
    exp_strobe = 1'b0;
    exp_dup    = 1'b0;
    if (exp_q.size() > 0 && cyc >= next_free) begin
      e          = exp_q.pop_front();
      exp_strobe = 1'b1;
      exp_dup    = (e == cur);
      cur        = e;
      next_free  = cyc + h;
    end
    if (push_now) exp_q.push_back(pe);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_q.delete();
    cur        = '0;
    next_free  = 0;
    exp_strobe = 1'b0;
    exp_dup    = 1'b0;
    check_all();
    rst = 1'b0;
  endtask

  task automatic push_tick(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_clr   = c;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    cyc         = 0;
    next_free   = 0;
    cur         = '0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_clr      = 1'b0;
    hold_cycles = 4'd1;
    @(negedge clk);

    // Reset state
    do_reset();

    // Single entry, hold 2, then back to idle
    hold_cycles = 4'd2;
    push_tick(8'd3, 8'd5, 1'b0);
    repeat (4) tick();

    // Fill the FIFO behind a long-held entry, then drain at hold 3
    hold_cycles = 4'd15;
    push_tick(8'd1, 8'd1, 1'b0);
    tick();
    hold_cycles = 4'd3;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      in_clr   = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (30) tick();

    // Duplicate pair at hold 1
    hold_cycles = 4'd1;
    in_valid = 1'b1;
    in_a = 8'd7; in_b = 8'd7; in_clr = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Clear level toggling
    push_tick(8'd0, 8'd0, 1'b1);
    push_tick(8'd0, 8'd0, 1'b0);
    repeat (3) tick();

    // Hold 0 behaves as hold 1
    hold_cycles = 4'd0;
    in_valid = 1'b1;
    in_a = 8'd9; in_b = 8'd2; in_clr = 1'b1;
    tick();
    in_a = 8'd4; in_b = 8'd6; in_clr = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Reset during HOLD with entries queued
    hold_cycles = 4'd6;
    push_tick(8'd11, 8'd12, 1'b1);
    push_tick(8'd13, 8'd14, 1'b0);
    push_tick(8'd15, 8'd16, 1'b1);
    tick();
    do_reset();
    repeat (5) tick();
    hold_cycles = 4'd2;
    push_tick(8'd21, 8'd22, 1'b0);
    repeat (3) tick();

    // Randomized traffic with small operand ranges to provoke duplicates
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        in_valid    = ($urandom_range(0, 2) != 0);
        in_a        = 8'($urandom_range(0, 2));
        in_b        = 8'($urandom_range(0, 2));
        in_clr      = 1'($urandom_range(0, 1));
        hold_cycles = 4'($urandom_range(0, 4));
        tick();
      end
    end
    in_valid = 1'b0;
    repeat (80) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
